store_rs_queue: RTL and testbench
=================================

STORE_RS_QUEUE -- requirements
Module: store_rs_queue

Interface
REQ-001 SHALL have parameter DEPTH, default 4, number of store entries (>=2).
REQ-002 SHALL have parameter XLEN, default 32, data/address width.
REQ-003 SHALL have parameter TAGW, default 6, ROB tag width.
REQ-004 SHALL have parameter INVALID_TAG, default 16; an operand tag equal to it means the operand value is present.
REQ-005 SHALL have parameter IN_ORDER, default 1; 1 = issue oldest entry only, 0 = issue oldest ready entry.
REQ-006 clock  input  1  single clock, rising edge.
REQ-007 reset  input  1  synchronous, active-high.
REQ-008 flush  input  1  discard all state (mispredict).
REQ-009 disp_valid  input  1  dispatch request.
REQ-010 disp_ready  output  1  entry free.
REQ-011 disp_subtype  input  3  000 SB, 001 SH, 010 SW.
REQ-012 disp_data1 / disp_q1  input  XLEN / TAGW  store value / its producer tag.
REQ-013 disp_data2 / disp_q2  input  XLEN / TAGW  base address / its producer tag.
REQ-014 disp_offset  input  XLEN  immediate offset.
REQ-015 disp_rob  input  TAGW  ROB tag of the store.
REQ-016 cdb0_valid, cdb0_tag, cdb0_data  input  1, TAGW, XLEN  broadcast bus 0.
REQ-017 cdb1_valid, cdb1_tag, cdb1_data  input  1, TAGW, XLEN  broadcast bus 1.
REQ-018 issue_valid  output  1  issue register holds a store.
REQ-019 issue_ready  input  1  memory unit accepts.
REQ-020 issue_rob, issue_value, issue_addr, issue_subtype  output  TAGW, XLEN, XLEN, 3  issued store.
REQ-021 count  output  $clog2(DEPTH+1)  occupied entries, issue register excluded.

Function
REQ-022 disp_ready SHALL equal (count < DEPTH), from registered state only; dispatch accepted on disp_valid && disp_ready && !flush.
REQ-023 Accepted dispatch SHALL write one free entry at the edge, recording age order (later dispatch = younger).
REQ-024 Dispatch bypass: an operand whose q matches a same-cycle valid CDB tag SHALL be stored with that CDB data and INVALID_TAG.
REQ-025 Each cycle every occupied entry with q1 or q2 matching a valid CDB tag SHALL capture cdb_data and set that q to INVALID_TAG.
REQ-026 Both CDBs valid with equal tags: cdb0 data SHALL win.
REQ-027 An entry is ready when q1 == q2 == INVALID_TAG, judged from registered state.
REQ-028 Selection: IN_ORDER=1 -> oldest entry, only if ready; IN_ORDER=0 -> oldest ready entry.
REQ-029 Issue register SHALL load the selected entry when empty or when issue_valid && issue_ready this cycle; the entry is freed the same edge.
REQ-030 issue_addr SHALL be data2 + offset, modulo 2^XLEN; issue_value = data1; issue_subtype, issue_rob copied.
REQ-031 Issue outputs SHALL hold stable while issue_valid && !issue_ready.
REQ-032 Latency: entry ready after edge N, issue register empty -> issue_valid high after edge N+1.
REQ-033 Full throughput: one dispatch and one issue per cycle simultaneously; count unchanged in that case.
REQ-034 count SHALL update at the edge: +1 on accepted dispatch, -1 on entry moved to issue register.
REQ-035 flush SHALL, at the edge, invalidate all entries and the issue register; dispatch that cycle ignored; flush takes priority over dispatch, CDB and issue.
REQ-036 Unknown subtypes SHALL be stored and issued unchanged.

Reset
REQ-037 reset SHALL, at the edge, clear all entries and the issue register: count=0, disp_ready=1, issue_valid=0, issue_rob=INVALID_TAG, issue_value=0, issue_addr=0, issue_subtype=0.
REQ-038 reset SHALL take priority over flush, dispatch, CDB and issue_ready; a store in flight mid-handshake is dropped.

Verification
REQ-039 Dispatch SW value 0xDEAD_BEEF, base 0x100, offset 0x8, both tags INVALID, issue_ready=1 -> issue_valid one cycle later with issue_addr=0x108, issue_value=0xDEADBEEF, count back to 0.
REQ-040 Fill DEPTH=4 with q1=3 pending, issue_ready=1 -> disp_ready=0, count=4; cdb0 tag 3 data 0x55 -> all four issue oldest-first at one per cycle, each value 0x55.
REQ-041 IN_ORDER=0: entry A (q1=5) older than B (ready) -> B issues first; IN_ORDER=1 -> nothing issues until tag 5 broadcast, then A then B.
REQ-042 Dispatch with q2=7 while cdb1 tag 7 data 0x2000 same cycle -> entry ready next cycle, issue_addr=0x2000+offset.
REQ-043 issue_valid high, issue_ready=0 for 3 cycles -> outputs constant; flush asserted -> issue_valid=0, count=0 next cycle.
REQ-044 Reset asserted mid-handshake with 3 entries -> count=0, issue_valid=0, disp_ready=1 after the edge; CDB broadcast in that cycle ignored.

Source files
------------

// File: rtl/store_rs_queue.sv
// -----------------------------------------------------------------------------
// store_rs_queue
//   Reservation-station queue for store instructions. Stores wait here until
//   both operands (store value and base address) have been produced, snooping
//   two result broadcast buses. A ready store moves into a single issue
//   register that presents value, effective address, subtype and ROB tag to
//   the memory unit with a valid/ready handshake.
//
//   Entries are kept in a collapsing array: slot 0 is always the oldest and
//   slot count-1 the youngest. Removing a slot shifts the younger ones down,
//   and a new dispatch is appended behind the survivors.
//
// Ports
//   clock, reset        rising-edge clock, synchronous active-high reset
//   flush               drop every queued store and the issue register
//   disp_*              dispatch request (valid/ready) and store operands
//   cdb0_*, cdb1_*      result broadcast buses (tag/data), cdb0 wins on a tie
//   issue_*             issued store towards the memory unit (valid/ready)
//   count               occupied queue entries (issue register not counted)
// -----------------------------------------------------------------------------
module store_rs_queue #(
    parameter int DEPTH       = 4,
    parameter int XLEN        = 32,
    parameter int TAGW        = 6,
    parameter int INVALID_TAG = 16,
    parameter int IN_ORDER    = 1
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       flush,
    input  logic                       disp_valid,
    output logic                       disp_ready,
    input  logic [2:0]                 disp_subtype,
    input  logic [XLEN-1:0]            disp_data1,
    input  logic [TAGW-1:0]            disp_q1,
    input  logic [XLEN-1:0]            disp_data2,
    input  logic [TAGW-1:0]            disp_q2,
    input  logic [XLEN-1:0]            disp_offset,
    input  logic [TAGW-1:0]            disp_rob,
    input  logic                       cdb0_valid,
    input  logic [TAGW-1:0]            cdb0_tag,
    input  logic [XLEN-1:0]            cdb0_data,
    input  logic                       cdb1_valid,
    input  logic [TAGW-1:0]            cdb1_tag,
    input  logic [XLEN-1:0]            cdb1_data,
    output logic                       issue_valid,
    input  logic                       issue_ready,
    output logic [TAGW-1:0]            issue_rob,
    output logic [XLEN-1:0]            issue_value,
    output logic [XLEN-1:0]            issue_addr,
    output logic [2:0]                 issue_subtype,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int CW = $clog2(DEPTH + 1);
    localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [TAGW-1:0] INV_TAG = TAGW'(INVALID_TAG);

    typedef struct packed {
        logic [XLEN-1:0] data1;
        logic [TAGW-1:0] q1;
        logic [XLEN-1:0] data2;
        logic [TAGW-1:0] q2;
        logic [XLEN-1:0] offset;
        logic [TAGW-1:0] rob;
        logic [2:0]      subtype;
    } entry_t;

    // Replace a pending operand with broadcast data when its tag is seen.
    // A present operand (INV_TAG) never matches, so a bus carrying that tag
    // cannot corrupt it. cdb0 is checked first so it wins on equal tags.
    function automatic logic [XLEN+TAGW-1:0] snoop(
        input logic [XLEN-1:0] d,
        input logic [TAGW-1:0] q,
        input logic            c0_v,
        input logic [TAGW-1:0] c0_t,
        input logic [XLEN-1:0] c0_d,
        input logic            c1_v,
        input logic [TAGW-1:0] c1_t,
        input logic [XLEN-1:0] c1_d
    );
        logic [XLEN+TAGW-1:0] res;
        if (q != INV_TAG && c0_v && c0_t == q) begin
            res = {c0_d, INV_TAG};
        end else if (q != INV_TAG && c1_v && c1_t == q) begin
            res = {c1_d, INV_TAG};
        end else begin
            res = {d, q};
        end
        return res;
    endfunction

    entry_t          r_ent [DEPTH];
    logic [CW-1:0]   r_count;
    logic            r_issue_valid;
    logic [TAGW-1:0] r_issue_rob;
    logic [XLEN-1:0] r_issue_value;
    logic [XLEN-1:0] r_issue_addr;
    logic [2:0]      r_issue_subtype;

    entry_t          w_upd  [DEPTH];
    entry_t          w_next [DEPTH];
    entry_t          w_new;
    entry_t          w_sel_ent;
    logic [DEPTH-1:0] w_ready;
    logic [IW-1:0]   w_sel;
    logic            w_sel_found;
    logic            w_load;
    logic            w_disp;
    logic [CW-1:0]   w_base;
    logic [CW-1:0]   w_count_next;

    assign disp_ready    = (r_count < CW'(DEPTH));
    assign count         = r_count;
    assign issue_valid   = r_issue_valid;
    assign issue_rob     = r_issue_rob;
    assign issue_value   = r_issue_value;
    assign issue_addr    = r_issue_addr;
    assign issue_subtype = r_issue_subtype;

    // Readiness, selection, CDB snooping and next-state of the collapsing array.
    always_comb begin
        w_disp      = disp_valid && disp_ready && !flush;
        w_sel_found = 1'b0;
        w_sel       = '0;

        // Readiness looks only at registered operand tags.
        for (int i = 0; i < DEPTH; i++) begin
            w_ready[i] = (i < int'(r_count)) && (r_ent[i].q1 == INV_TAG)
                         && (r_ent[i].q2 == INV_TAG);
        end

        if (IN_ORDER != 0) begin
            w_sel_found = w_ready[0];
            w_sel       = '0;
        end else begin
            // Scan youngest to oldest so the last hit is the oldest ready slot.
            for (int i = DEPTH - 1; i >= 0; i--) begin
                w_sel       = w_ready[i] ? IW'(i) : w_sel;
                w_sel_found = w_sel_found | w_ready[i];
            end
        end

        w_sel_ent = r_ent[w_sel];
        w_load    = w_sel_found && (!r_issue_valid || issue_ready);

        for (int i = 0; i < DEPTH; i++) begin
            w_upd[i] = r_ent[i];
            {w_upd[i].data1, w_upd[i].q1} = snoop(r_ent[i].data1, r_ent[i].q1,
                cdb0_valid, cdb0_tag, cdb0_data, cdb1_valid, cdb1_tag, cdb1_data);
            {w_upd[i].data2, w_upd[i].q2} = snoop(r_ent[i].data2, r_ent[i].q2,
                cdb0_valid, cdb0_tag, cdb0_data, cdb1_valid, cdb1_tag, cdb1_data);
        end

        // Incoming store also snoops the buses in its dispatch cycle.
        w_new.offset  = disp_offset;
        w_new.rob     = disp_rob;
        w_new.subtype = disp_subtype;
        {w_new.data1, w_new.q1} = snoop(disp_data1, disp_q1,
            cdb0_valid, cdb0_tag, cdb0_data, cdb1_valid, cdb1_tag, cdb1_data);
        {w_new.data2, w_new.q2} = snoop(disp_data2, disp_q2,
            cdb0_valid, cdb0_tag, cdb0_data, cdb1_valid, cdb1_tag, cdb1_data);

        // Slots at or above the removed one take their younger neighbour.
        w_base = r_count - CW'(w_load);
        for (int i = 0; i < DEPTH; i++) begin
            if (w_load && (i >= int'(w_sel)) && (i < DEPTH - 1)) begin
                w_next[i] = w_upd[(i + 1 < DEPTH) ? i + 1 : i];
            end else begin
                w_next[i] = w_upd[i];
            end
            if (w_disp && (i == int'(w_base))) begin
                w_next[i] = w_new;
            end else begin
                w_next[i] = w_next[i];
            end
        end

        w_count_next = r_count + CW'(w_disp) - CW'(w_load);
    end

    // State update: reset beats flush, flush beats dispatch/snoop/issue.
    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_ent[i] <= '0;
            end
            r_count         <= '0;
            r_issue_valid   <= 1'b0;
            r_issue_rob     <= INV_TAG;
            r_issue_value   <= '0;
            r_issue_addr    <= '0;
            r_issue_subtype <= 3'd0;
        end else if (flush) begin
            r_count       <= '0;
            r_issue_valid <= 1'b0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                r_ent[i] <= w_next[i];
            end
            r_count <= w_count_next;
            if (w_load) begin
                r_issue_valid   <= 1'b1;
                r_issue_rob     <= w_sel_ent.rob;
                r_issue_value   <= w_sel_ent.data1;
                r_issue_addr    <= w_sel_ent.data2 + w_sel_ent.offset;
                r_issue_subtype <= w_sel_ent.subtype;
            end else if (issue_ready) begin
                r_issue_valid <= 1'b0;
            end else begin
                r_issue_valid <= r_issue_valid;
            end
        end
    end

endmodule

// File: tb/tb_store_rs_queue.sv
// -----------------------------------------------------------------------------
// tb_store_rs_queue
//   Directed bench for store_rs_queue. Two instances share all inputs: dut
//   (in-order issue) and dut_ooo (oldest-ready issue). Expected issued stores
//   go into per-instance queues; monitors pop and compare on every completed
//   issue handshake. Register-level values are checked inline.
// -----------------------------------------------------------------------------
module tb_store_rs_queue;

    typedef struct packed {
        logic [5:0]  rob;
        logic [31:0] value;
        logic [31:0] addr;
        logic [2:0]  sub;
    } exp_t;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        flush = 1'b0;
    logic        disp_valid = 1'b0;
    logic [2:0]  disp_subtype = 3'd0;
    logic [31:0] disp_data1 = 32'd0, disp_data2 = 32'd0, disp_offset = 32'd0;
    logic [5:0]  disp_q1 = 6'd16, disp_q2 = 6'd16, disp_rob = 6'd0;
    logic        cdb0_valid = 1'b0, cdb1_valid = 1'b0;
    logic [5:0]  cdb0_tag = 6'd0, cdb1_tag = 6'd0;
    logic [31:0] cdb0_data = 32'd0, cdb1_data = 32'd0;
    logic        issue_ready = 1'b0;

    logic        disp_ready, issue_valid;
    logic [5:0]  issue_rob;
    logic [31:0] issue_value, issue_addr;
    logic [2:0]  issue_subtype;
    logic [2:0]  count;

    logic        o_disp_ready, o_issue_valid;
    logic [5:0]  o_issue_rob;
    logic [31:0] o_issue_value, o_issue_addr;
    logic [2:0]  o_issue_subtype;
    logic [2:0]  o_count;

    int   vectors = 0;
    int   miscompares = 0;
    bit   chk_ooo = 1'b0;
    exp_t exp_q[$];
    exp_t exp_ooo[$];

    always #5 clock = ~clock;

    store_rs_queue #(.IN_ORDER(1)) dut (
        .clock(clock), .reset(reset), .flush(flush),
        .disp_valid(disp_valid), .disp_ready(disp_ready), .disp_subtype(disp_subtype),
        .disp_data1(disp_data1), .disp_q1(disp_q1), .disp_data2(disp_data2),
        .disp_q2(disp_q2), .disp_offset(disp_offset), .disp_rob(disp_rob),
        .cdb0_valid(cdb0_valid), .cdb0_tag(cdb0_tag), .cdb0_data(cdb0_data),
        .cdb1_valid(cdb1_valid), .cdb1_tag(cdb1_tag), .cdb1_data(cdb1_data),
        .issue_valid(issue_valid), .issue_ready(issue_ready), .issue_rob(issue_rob),
        .issue_value(issue_value), .issue_addr(issue_addr),
        .issue_subtype(issue_subtype), .count(count)
    );

    store_rs_queue #(.IN_ORDER(0)) dut_ooo (
        .clock(clock), .reset(reset), .flush(flush),
        .disp_valid(disp_valid), .disp_ready(o_disp_ready), .disp_subtype(disp_subtype),
        .disp_data1(disp_data1), .disp_q1(disp_q1), .disp_data2(disp_data2),
        .disp_q2(disp_q2), .disp_offset(disp_offset), .disp_rob(disp_rob),
        .cdb0_valid(cdb0_valid), .cdb0_tag(cdb0_tag), .cdb0_data(cdb0_data),
        .cdb1_valid(cdb1_valid), .cdb1_tag(cdb1_tag), .cdb1_data(cdb1_data),
        .issue_valid(o_issue_valid), .issue_ready(issue_ready), .issue_rob(o_issue_rob),
        .issue_value(o_issue_value), .issue_addr(o_issue_addr),
        .issue_subtype(o_issue_subtype), .count(o_count)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic cmp_issue(input string who, input exp_t e, input logic [5:0] rob,
                             input logic [31:0] val, input logic [31:0] addr,
                             input logic [2:0] sub);
        check({who, ".rob"},   {26'd0, rob}, {26'd0, e.rob});
        check({who, ".value"}, val, e.value);
        check({who, ".addr"},  addr, e.addr);
        check({who, ".sub"},   {29'd0, sub}, {29'd0, e.sub});
    endtask

    // Monitor for the in-order instance: one pop per completed handshake.
    always @(negedge clock) begin
        if (!reset && !flush && issue_valid && issue_ready) begin
            if (exp_q.size() == 0) begin
                check("inorder_unexpected_issue", {26'd0, issue_rob}, 32'hFFFF_FFFF);
            end else begin
                cmp_issue("inorder", exp_q.pop_front(), issue_rob, issue_value,
                          issue_addr, issue_subtype);
            end
        end
    end

    // Monitor for the out-of-order instance, active only in its own test.
    always @(negedge clock) begin
        if (chk_ooo && !reset && !flush && o_issue_valid && issue_ready) begin
            if (exp_ooo.size() == 0) begin
                check("ooo_unexpected_issue", {26'd0, o_issue_rob}, 32'hFFFF_FFFF);
            end else begin
                cmp_issue("ooo", exp_ooo.pop_front(), o_issue_rob, o_issue_value,
                          o_issue_addr, o_issue_subtype);
            end
        end
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic disp(input logic [2:0] sub, input logic [31:0] d1, input logic [5:0] q1,
                        input logic [31:0] d2, input logic [5:0] q2,
                        input logic [31:0] off, input logic [5:0] rob);
        disp_valid = 1'b1; disp_subtype = sub;
        disp_data1 = d1; disp_q1 = q1; disp_data2 = d2; disp_q2 = q2;
        disp_offset = off; disp_rob = rob;
    endtask

    task automatic idle();
        disp_valid = 1'b0; cdb0_valid = 1'b0; cdb1_valid = 1'b0;
    endtask

    initial begin
        logic [2:0] subs [4];
        subs[0] = 3'd0; subs[1] = 3'd1; subs[2] = 3'd2; subs[3] = 3'd7;

        // Reset values
        tick(); tick();
        reset = 1'b0;
        check("rst_count", {29'd0, count}, 32'd0);
        check("rst_disp_ready", {31'd0, disp_ready}, 32'd1);
        check("rst_issue_valid", {31'd0, issue_valid}, 32'd0);
        check("rst_issue_rob", {26'd0, issue_rob}, 32'd16);
        check("rst_issue_value", issue_value, 32'd0);
        check("rst_issue_addr", issue_addr, 32'd0);
        check("rst_issue_sub", {29'd0, issue_subtype}, 32'd0);

        // Single ready SW: address 0x100 + 0x8
        issue_ready = 1'b1;
        disp(3'd2, 32'hDEAD_BEEF, 6'd16, 32'h100, 6'd16, 32'h8, 6'd1);
        exp_q.push_back('{6'd1, 32'hDEAD_BEEF, 32'h108, 3'd2});
        tick(); idle();
        check("sw_count_after_disp", {29'd0, count}, 32'd1);
        check("sw_valid_early", {31'd0, issue_valid}, 32'd0);
        tick();
        check("sw_issue_valid", {31'd0, issue_valid}, 32'd1);
        check("sw_count_zero", {29'd0, count}, 32'd0);
        tick();
        check("sw_issue_done", {31'd0, issue_valid}, 32'd0);

        // Fill with q1=3 pending, then one broadcast releases all four
        for (int i = 0; i < 4; i++) begin
            disp(subs[i], 32'h0, 6'd3, 32'h1000 + 32'(i * 4), 6'd16, 32'h0, 6'(10 + i));
            tick();
        end
        idle();
        check("full_count", {29'd0, count}, 32'd4);
        check("full_disp_ready", {31'd0, disp_ready}, 32'd0);
        check("full_no_issue", {31'd0, issue_valid}, 32'd0);
        disp(3'd0, 32'h9, 6'd16, 32'h9, 6'd16, 32'h0, 6'd20);
        tick(); idle();
        check("full_disp_ignored", {29'd0, count}, 32'd4);
        for (int i = 0; i < 4; i++) begin
            exp_q.push_back('{6'(10 + i), 32'h55, 32'h1000 + 32'(i * 4), subs[i]});
        end
        cdb0_valid = 1'b1; cdb0_tag = 6'd3; cdb0_data = 32'h55;
        tick(); idle();
        check("wake_no_issue_yet", {31'd0, issue_valid}, 32'd0);
        tick();
        check("wake_issue_valid", {31'd0, issue_valid}, 32'd1);
        check("wake_count3", {29'd0, count}, 32'd3);
        tick(); tick(); tick(); tick();
        check("drain_count", {29'd0, count}, 32'd0);
        check("drain_valid", {31'd0, issue_valid}, 32'd0);
        check("drain_queue_empty", exp_q.size(), 32'd0);

        // Dispatch bypass from cdb1 on the base address
        disp(3'd1, 32'h77, 6'd16, 32'h0, 6'd7, 32'h10, 6'd30);
        cdb1_valid = 1'b1; cdb1_tag = 6'd7; cdb1_data = 32'h2000;
        exp_q.push_back('{6'd30, 32'h77, 32'h2010, 3'd1});
        tick(); idle();
        tick();
        check("bypass_issue_valid", {31'd0, issue_valid}, 32'd1);
        tick();

        // Equal tags on both buses: cdb0 data wins
        disp(3'd0, 32'h0, 6'd9, 32'h300, 6'd16, 32'h4, 6'd31);
        exp_q.push_back('{6'd31, 32'hAAAA, 32'h304, 3'd0});
        tick(); idle();
        cdb0_valid = 1'b1; cdb0_tag = 6'd9; cdb0_data = 32'hAAAA;
        cdb1_valid = 1'b1; cdb1_tag = 6'd9; cdb1_data = 32'hBBBB;
        tick(); idle();
        tick(); tick();
        check("tie_queue_empty", exp_q.size(), 32'd0);

        // Stall: outputs hold while not accepted, then flush
        issue_ready = 1'b0;
        disp(3'd2, 32'h1234, 6'd16, 32'h40, 6'd16, 32'h0, 6'd40);
        tick();
        disp(3'd2, 32'h5678, 6'd16, 32'h80, 6'd16, 32'h0, 6'd41);
        tick(); idle();
        for (int i = 0; i < 3; i++) begin
            check("stall_valid", {31'd0, issue_valid}, 32'd1);
            check("stall_rob", {26'd0, issue_rob}, 32'd40);
            check("stall_value", issue_value, 32'h1234);
            check("stall_addr", issue_addr, 32'h40);
            check("stall_count", {29'd0, count}, 32'd1);
            tick();
        end
        flush = 1'b1; issue_ready = 1'b1;
        disp(3'd2, 32'h1, 6'd16, 32'h1, 6'd16, 32'h0, 6'd42);
        tick(); flush = 1'b0; idle();
        check("flush_valid", {31'd0, issue_valid}, 32'd0);
        check("flush_count", {29'd0, count}, 32'd0);
        tick();
        check("flush_disp_dropped", {31'd0, issue_valid}, 32'd0);

        // Reset mid-handshake with three queued entries
        issue_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            disp(3'd2, 32'(i), 6'd16, 32'h700, 6'd16, 32'h0, 6'(50 + i));
            tick();
        end
        idle();
        check("pre_rst_count", {29'd0, count}, 32'd3);
        check("pre_rst_valid", {31'd0, issue_valid}, 32'd1);
        reset = 1'b1; issue_ready = 1'b1;
        cdb0_valid = 1'b1; cdb0_tag = 6'd3; cdb0_data = 32'hFF;
        tick(); reset = 1'b0; idle();
        check("mid_rst_count", {29'd0, count}, 32'd0);
        check("mid_rst_valid", {31'd0, issue_valid}, 32'd0);
        check("mid_rst_disp_ready", {31'd0, disp_ready}, 32'd1);
        check("mid_rst_rob", {26'd0, issue_rob}, 32'd16);
        tick();
        check("post_rst_valid", {31'd0, issue_valid}, 32'd0);

        // Oldest-only vs oldest-ready selection
        flush = 1'b1; tick(); flush = 1'b0;
        chk_ooo = 1'b1;
        disp(3'd2, 32'h0, 6'd5, 32'h500, 6'd16, 32'h0, 6'd60);
        tick();
        disp(3'd2, 32'h61, 6'd16, 32'h600, 6'd16, 32'h0, 6'd61);
        exp_ooo.push_back('{6'd61, 32'h61, 32'h600, 3'd2});
        exp_ooo.push_back('{6'd60, 32'h5A5A, 32'h500, 3'd2});
        exp_q.push_back('{6'd60, 32'h5A5A, 32'h500, 3'd2});
        exp_q.push_back('{6'd61, 32'h61, 32'h600, 3'd2});
        tick(); idle();
        tick();
        check("ooo_b_first", {26'd0, o_issue_rob}, 32'd61);
        check("inorder_blocked", {31'd0, issue_valid}, 32'd0);
        tick(); tick();
        check("inorder_still_blocked", {31'd0, issue_valid}, 32'd0);
        cdb0_valid = 1'b1; cdb0_tag = 6'd5; cdb0_data = 32'h5A5A;
        tick(); idle();
        for (int i = 0; i < 5; i++) tick();
        check("ooo_queue_empty", exp_ooo.size(), 32'd0);
        check("inorder_queue_empty", exp_q.size(), 32'd0);
        check("final_count", {29'd0, count}, 32'd0);
        check("final_valid", {31'd0, issue_valid}, 32'd0);
        chk_ooo = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
